demo_sequencer: RTL and testbench

Plays a stored multi-channel tune by stepping through a note memory. Each entry is loaded into the channel mixer's control inputs (`channel_ena`, `waveforms`, `pitches`) and held for a programmed duration. The top level selects these outputs instead of the button-driven values while in DEMO mode. The note memory is an external synchronous ROM with 1-cycle read latency; this block owns its address.

---
 rtl/demo_seq_pkg.sv | 39 +++
 rtl/demo_tick_timer.sv | 52 +++++
 rtl/demo_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_demo_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demo_seq_pkg.sv
// Shared state type and note-entry field layout for demo_sequencer.
// StGap is only present when DEMO_SEQ_GAP_EN is defined.
package demo_seq_pkg;

  localparam int unsigned DUR_W  = 8;
  localparam int unsigned WAVE_W = 2;

`ifdef DEMO_SEQ_GAP_EN
  typedef enum logic [1:0] {StIdle, StFetch, StPlay, StGap} demo_state_t;
`else
  typedef enum logic [1:0] {StIdle, StFetch, StPlay} demo_state_t;
`endif

  // One channel field is {ena, wave, pitch}; CH_FIELD_W = C + 3.
  function automatic int unsigned ch_field_w(int unsigned c);
    return c + 1 + WAVE_W;
  endfunction

  function automatic int unsigned pitch_lsb(int unsigned ch, int unsigned c);
    return ch * ch_field_w(c);
  endfunction

  function automatic int unsigned wave_lsb(int unsigned ch, int unsigned c);
    return pitch_lsb(ch, c) + c;
  endfunction

  function automatic int unsigned ena_bit(int unsigned ch, int unsigned c);
    return wave_lsb(ch, c) + WAVE_W;
  endfunction

  function automatic int unsigned dur_lsb(int unsigned nch, int unsigned c);
    return nch * ch_field_w(c);
  endfunction

  function automatic int unsigned last_bit(int unsigned nch, int unsigned c);
    return dur_lsb(nch, c) + DUR_W;
  endfunction

endpackage

// File: rtl/demo_tick_timer.sv
// Prescaled duration timer: after load, expire pulses once dur*TICK_CYCLES cycles later.
// A dur of zero is treated as one.
module demo_tick_timer #(
  parameter int unsigned TICK_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] dur,
  output logic             expire
);

  localparam int unsigned PreW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(TICK_CYCLES - 1);

  logic [PreW-1:0]  pre_q;
  logic [CNT_W-1:0] ticks_q;
  logic [CNT_W-1:0] dur_q;
  logic             active_q;
  logic             wrap;

  assign wrap   = (pre_q == PreMax);
  assign expire = active_q && wrap && (ticks_q == dur_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q    <= '0;
      ticks_q  <= '0;
      dur_q    <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      pre_q    <= '0;
      ticks_q  <= CNT_W'(1);
      dur_q    <= (dur == '0) ? CNT_W'(1) : dur;
      active_q <= 1'b1;
    end else if (active_q) begin
      if (wrap) begin
        pre_q <= '0;
        if (ticks_q == dur_q) begin
          active_q <= 1'b0;
          ticks_q  <= '0;
        end else begin
          ticks_q <= ticks_q + 1'b1;
        end
      end else begin
        pre_q <= pre_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/demo_sequencer.sv
// Tune sequencer: steps an external 1-cycle-latency note ROM and drives the mixer controls.
// Define DEMO_SEQ_GAP_EN to insert GAP_CYCLES of silence between notes.
module demo_sequencer
  import demo_seq_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 2,
  parameter int unsigned C            = 12,
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned TICK_CYCLES  = 1_200_000,
  parameter int unsigned GAP_CYCLES   = 120_000,
  localparam int unsigned ENTRY_W     = 1 + DUR_W + NUM_CHANNELS * (C + 1 + WAVE_W)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             stop,
  output logic [ADDR_W-1:0]                rom_addr,
  input  logic [ENTRY_W-1:0]               rom_data,
  output logic [NUM_CHANNELS-1:0]          channel_ena,
  output logic [NUM_CHANNELS*WAVE_W-1:0]   waveforms,
  output logic [NUM_CHANNELS*C-1:0]        pitches,
  output logic                             busy,
  output logic                             done
);

  localparam int unsigned CH_FIELD_W = ch_field_w(C);
  localparam int unsigned DurLsb     = dur_lsb(NUM_CHANNELS, C);
  localparam int unsigned LastBit    = last_bit(NUM_CHANNELS, C);

  // Entry unpacking
  logic [NUM_CHANNELS-1:0]        entry_ena;
  logic [NUM_CHANNELS*WAVE_W-1:0] entry_wave;
  logic [NUM_CHANNELS*C-1:0]      entry_pitch;
  logic [DUR_W-1:0]               entry_dur;
  logic                           entry_last;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_unpack
    localparam int unsigned PitchLsb = pitch_lsb(g, C);
    localparam int unsigned WaveLsb  = wave_lsb(g, C);
    localparam int unsigned EnaBit   = ena_bit(g, C);
    assign entry_pitch[g*C +: C]           = rom_data[PitchLsb +: C];
    assign entry_wave[g*WAVE_W +: WAVE_W]  = rom_data[WaveLsb +: WAVE_W];
    assign entry_ena[g]                    = rom_data[EnaBit];
  end

  assign entry_dur  = rom_data[DurLsb +: DUR_W];
  assign entry_last = rom_data[LastBit];

  // State and registered outputs
  demo_state_t                    state_q, state_d;
  logic [ADDR_W-1:0]              rom_addr_q;
  logic [ADDR_W-1:0]              cur_addr_q;
  logic [ADDR_W-1:0]              next_addr;
  logic                           last_q;
  logic [NUM_CHANNELS-1:0]        ena_q;
  logic [NUM_CHANNELS*WAVE_W-1:0] wave_q;
  logic [NUM_CHANNELS*C-1:0]      pitch_q;
  logic                           busy_q;
  logic                           done_q;

  logic load_note;
  logic go_idle;
  logic fin;
  logic note_expire;
  logic at_end;

  // The top entry always terminates, so the prefetch address saturates instead of wrapping.
  assign next_addr = (rom_addr_q == {ADDR_W{1'b1}}) ? rom_addr_q : rom_addr_q + 1'b1;
  assign at_end    = last_q || (cur_addr_q == {ADDR_W{1'b1}});

  demo_tick_timer #(
    .TICK_CYCLES (TICK_CYCLES),
    .CNT_W       (DUR_W)
  ) u_note_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (load_note),
    .dur    (entry_dur),
    .expire (note_expire)
  );

`ifdef DEMO_SEQ_GAP_EN
  localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  logic gap_load;
  logic gap_expire;

  // Same timer with a unit prescale, loaded with a raw cycle count.
  demo_tick_timer #(
    .TICK_CYCLES (1),
    .CNT_W       (GapW)
  ) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (gap_load),
    .dur    (GapW'(GAP_CYCLES)),
    .expire (gap_expire)
  );
`else
  logic unused_gap_cycles;
  assign unused_gap_cycles = ^GAP_CYCLES;
`endif

  always_comb begin
    state_d   = state_q;
    load_note = 1'b0;
    go_idle   = 1'b0;
    fin       = 1'b0;
`ifdef DEMO_SEQ_GAP_EN
    gap_load  = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (start && !stop) state_d = StFetch;
      end
      StFetch: begin
        if (stop) begin
          go_idle = 1'b1;
        end else begin
          load_note = 1'b1;
          state_d   = StPlay;
        end
      end
      StPlay: begin
        if (stop) begin
          go_idle = 1'b1;
        end else if (note_expire) begin
          if (at_end) begin
            go_idle = 1'b1;
            fin     = 1'b1;
          end else begin
`ifdef DEMO_SEQ_GAP_EN
            gap_load = 1'b1;
            state_d  = StGap;
`else
            load_note = 1'b1;
`endif
          end
        end
      end
`ifdef DEMO_SEQ_GAP_EN
      StGap: begin
        if (stop) begin
          go_idle = 1'b1;
        end else if (gap_expire) begin
          load_note = 1'b1;
          state_d   = StPlay;
        end
      end
`endif
      default: go_idle = 1'b1;
    endcase
    if (go_idle) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      rom_addr_q <= '0;
      cur_addr_q <= '0;
      last_q     <= 1'b0;
      ena_q      <= '0;
      wave_q     <= '0;
      pitch_q    <= '1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != StIdle);
      done_q  <= fin;
      if (go_idle) begin
        rom_addr_q <= '0;
        cur_addr_q <= '0;
        last_q     <= 1'b0;
        ena_q      <= '0;
        wave_q     <= '0;
        pitch_q    <= '1;
      end else if (load_note) begin
        ena_q      <= entry_ena;
        wave_q     <= entry_wave;
        pitch_q    <= entry_pitch;
        last_q     <= entry_last;
        cur_addr_q <= rom_addr_q;
        rom_addr_q <= next_addr;
`ifdef DEMO_SEQ_GAP_EN
      end else if (gap_load) begin
        ena_q <= '0;
`endif
      end
    end
  end

  assign rom_addr    = rom_addr_q;
  assign channel_ena = ena_q;
  assign waveforms   = wave_q;
  assign pitches     = pitch_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_demo_sequencer.sv
// Self-checking bench for demo_sequencer: expected per-cycle outputs are derived from the tune.
`timescale 1ns/1ps
module tb_demo_sequencer;

  localparam int unsigned NCH   = 2;
  localparam int unsigned CW    = 12;
  localparam int unsigned AW    = 3;
  localparam int unsigned TICK  = 4;
  localparam int unsigned GAP   = 3;
  localparam int unsigned EW    = 1 + 8 + NCH * (CW + 3);
  localparam int unsigned DEPTH = 8;

  // {rom_addr, channel_ena, waveforms, pitches, busy, done}
  typedef logic [34:0] obs_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [AW-1:0]     rom_addr;
  logic [EW-1:0]     rom_data;
  logic [NCH-1:0]    channel_ena;
  logic [2*NCH-1:0]  waveforms;
  logic [NCH*CW-1:0] pitches;
  logic              busy;
  logic              done;
  obs_t              obs;

  logic [EW-1:0] rom [DEPTH];
  logic          m_last  [DEPTH];
  int            m_dur   [DEPTH];
  logic [1:0]    m_ena   [DEPTH];
  logic [3:0]    m_wave  [DEPTH];
  logic [23:0]   m_pitch [DEPTH];

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];

  demo_sequencer #(
    .NUM_CHANNELS (NCH),
    .C            (CW),
    .ADDR_W       (AW),
    .TICK_CYCLES  (TICK),
    .GAP_CYCLES   (GAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .channel_ena (channel_ena),
    .waveforms   (waveforms),
    .pitches     (pitches),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  assign obs = {rom_addr, channel_ena, waveforms, pitches, busy, done};

  initial begin
    #1_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  function automatic obs_t idle_obs(input logic d);
    return {3'd0, 2'b00, 4'h0, 24'hFFFFFF, 1'b0, d};
  endfunction

  task automatic check(input string tag, input obs_t got, input obs_t want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic load_rom();
    for (int k = 0; k < DEPTH; k++)
      rom[k] = {m_last[k], 8'(m_dur[k]),
                m_ena[k][1], m_wave[k][3:2], m_pitch[k][23:12],
                m_ena[k][0], m_wave[k][1:0], m_pitch[k][11:0]};
  endtask

  task automatic set_blank();
    for (int k = 0; k < DEPTH; k++) begin
      m_last[k]  = 1'b0;
      m_dur[k]   = 1;
      m_ena[k]   = 2'b00;
      m_wave[k]  = 4'h0;
      m_pitch[k] = 24'h0;
    end
  endtask

  task automatic set_random(input bit allow_last);
    for (int k = 0; k < DEPTH; k++) begin
      m_last[k]  = allow_last && ($urandom_range(3) == 0);
      m_dur[k]   = $urandom_range(2);
      m_ena[k]   = 2'($urandom_range(3));
      m_wave[k]  = 4'($urandom_range(15));
      m_pitch[k] = 24'($urandom);
    end
  endtask

  // Expected trace from the start edge: one FETCH cycle, each note for max(dur,1)*TICK
  // cycles (plus a silent gap between notes when enabled), then a done pulse and idle.
  task automatic build_expect();
    logic [2:0] nxt;
    int         n;
    bit         fin;
    exp_q.delete();
    exp_q.push_back({3'd0, 2'b00, 4'h0, 24'hFFFFFF, 1'b1, 1'b0});
    for (int k = 0; k < DEPTH; k++) begin
      nxt = (k == DEPTH - 1) ? 3'(k) : 3'(k + 1);
      n   = ((m_dur[k] == 0) ? 1 : m_dur[k]) * TICK;
      fin = m_last[k] || (k == DEPTH - 1);
      repeat (n) exp_q.push_back({nxt, m_ena[k], m_wave[k], m_pitch[k], 1'b1, 1'b0});
      if (fin) break;
`ifdef DEMO_SEQ_GAP_EN
      repeat (GAP) exp_q.push_back({nxt, 2'b00, m_wave[k], m_pitch[k], 1'b1, 1'b0});
`endif
    end
    exp_q.push_back(idle_obs(1'b1));
    exp_q.push_back(idle_obs(1'b0));
  endtask

  // Play the current tune; stop_at >= 0 raises stop after that many observed cycles.
  task automatic run_tune(input string tag, input int stop_at);
    build_expect();
    load_rom();
    start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < exp_q.size(); i++) begin
      check(tag, obs, exp_q[i]);
      if (i == stop_at) begin
        stop  = 1'b1;
        start = 1'($urandom_range(1));
        @(posedge clk); #1;
        stop  = 1'b0;
        start = 1'b0;
        check({tag, "_stop"}, obs, idle_obs(1'b0));
        @(posedge clk); #1;
        check({tag, "_stop_hold"}, obs, idle_obs(1'b0));
        return;
      end
      // start is ignored while busy; keep it low once idle so no replay begins
      start = exp_q[i][1] ? 1'($urandom_range(1)) : 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic set_basic();
    set_blank();
    m_ena[0]   = 2'b01;
    m_wave[0]  = {2'd0, 2'd1};
    m_pitch[0] = {12'd0, 12'd212};
    m_dur[0]   = 2;
    m_ena[1]   = 2'b10;
    m_pitch[1] = {12'd106, 12'd0};
    m_dur[1]   = 1;
    m_last[1]  = 1'b1;
  endtask

  initial begin
    set_blank();
    load_rom();

    // Reset held low with random start
    rst = 1'b0;
    repeat (5) begin
      start = 1'($urandom_range(1));
      @(posedge clk); #1;
      check("reset", obs, idle_obs(1'b0));
    end
    start = 1'b0;
    rst   = 1'b1;
    @(posedge clk); #1;
    check("post_reset", obs, idle_obs(1'b0));

    set_basic();
    run_tune("basic", -1);

    set_blank();
    m_ena[0]   = 2'b11;
    m_wave[0]  = 4'h9;
    m_pitch[0] = 24'h123456;
    m_dur[0]   = 0;
    m_last[0]  = 1'b1;
    run_tune("dur0", -1);

    set_random(1'b0);
    run_tune("all8", -1);

    set_basic();
    run_tune("stop", 3);

    // start and stop together while idle
    start = 1'b1;
    stop  = 1'b1;
    @(posedge clk); #1;
    check("start_stop", obs, idle_obs(1'b0));
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
    check("start_stop_hold", obs, idle_obs(1'b0));

    // asynchronous reset mid-play
    set_basic();
    load_rom();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", obs, idle_obs(1'b0));
    @(posedge clk); #1;
    check("async_reset_hold", obs, idle_obs(1'b0));
    rst = 1'b1;
    @(posedge clk); #1;
    check("after_async_reset", obs, idle_obs(1'b0));

    repeat (8) begin
      set_random(1'b1);
      run_tune("random", ($urandom_range(1) == 1) ? int'($urandom_range(40)) : -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
